// File: rtl/alu_pwr_pkg.sv
// Shared types for the ALU power sequencer.
//   pwr_mode_t  : nested power modes (full > normal > low > sleep)
//   DOM_*       : bit positions of the memory/arithmetic/logic domains
//   mode_mask() : supply domains that must be up for a given mode
//   seq_state_t : sequencer FSM states
package alu_pwr_pkg;

  typedef enum logic [1:0] {
    MODE_SLEEP  = 2'b00,
    MODE_LOW    = 2'b01,
    MODE_NORMAL = 2'b10,
    MODE_FULL   = 2'b11
  } pwr_mode_t;

  localparam int unsigned NUM_DOM = 3;
  localparam int unsigned DOM_M   = 2;
  localparam int unsigned DOM_A   = 1;
  localparam int unsigned DOM_L   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISO_ON,    // go_sleep already lowered, isolation asserted on exit
    ST_PWR_OFF,   // isolation held for ISO_DLY, supplies dropped on exit
    ST_PWR_ON,    // first ack-test cycle after supplies were enabled
    ST_WAIT_ACK,  // remaining ack-test cycles
    ST_ISO_OFF,   // isolation released, mode committed on exit
    ST_COMMIT
  } seq_state_t;

  // Modes are nested, so each mask is a superset of the next lower one.
  function automatic logic [NUM_DOM-1:0] mode_mask(input pwr_mode_t m);
    logic [NUM_DOM-1:0] mask;
    mask = '0;
    case (m)
      MODE_FULL: begin
        mask[DOM_M] = 1'b1;
        mask[DOM_A] = 1'b1;
        mask[DOM_L] = 1'b1;
      end
      MODE_NORMAL: begin
        mask[DOM_A] = 1'b1;
        mask[DOM_L] = 1'b1;
      end
      MODE_LOW: begin
        mask[DOM_A] = 1'b1;
      end
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/alu_power_sequencer_pwr_timer.sv
// pwr_timer: loadable down-counter shared by the isolation-hold and
// power-up-timeout phases.
//   clk, rst_n  : clock, synchronous active-low reset (clears the count)
//   load_i      : load load_val_i into the counter this edge
//   load_val_i  : value to load
//   expire_o    : high during the last counted cycle (count == 1)
module pwr_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Loading N makes expire_o high in the N-th cycle after the load edge.
  assign expire_o = (count_q == W'(1));

endmodule

// File: rtl/alu_power_sequencer.sv
// alu_power_sequencer: power-mode controller in front of dummyALU.
// Drives the ALU go_sleep mode and sequences supply enables and isolation
// for the M/A/L domains. Power-down: go_sleep, isolation, supply off.
// Power-up: supply on, wait ack, de-isolate, go_sleep.
//   clk, rst_n  : clock, synchronous active-low reset
//   req_valid   : mode-change request (ignored unless req_ready)
//   mode_req    : requested mode (11 full, 10 normal, 01 low, 00 sleep)
//   req_ready   : high while idle
//   pwr_ack     : per-domain supply-good {M,A,L}
//   pwr_en      : per-domain supply enable {M,A,L}
//   iso_en      : per-domain isolation enable {M,A,L}
//   go_sleep    : mode presented to the ALU
//   mode_cur    : committed mode
//   done        : one-cycle pulse when a request completes
//   err         : one-cycle pulse with done on power-up timeout
module alu_power_sequencer
  import alu_pwr_pkg::*;
#(
  parameter int unsigned ISO_DLY    = 2,
  parameter int unsigned TIMEOUT    = 8,
  parameter pwr_mode_t   RESET_MODE = MODE_FULL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] mode_req,
  output logic       req_ready,
  input  logic [2:0] pwr_ack,
  output logic [2:0] pwr_en,
  output logic [2:0] iso_en,
  output logic [1:0] go_sleep,
  output logic [1:0] mode_cur,
  output logic       done,
  output logic       err
);

  localparam int unsigned TMAX = (ISO_DLY > TIMEOUT) ? ISO_DLY : TIMEOUT;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] ISO_LD = TW'(ISO_DLY);
  localparam logic [TW-1:0] TMO_LD = TW'(TIMEOUT);
  localparam logic [NUM_DOM-1:0] RST_MASK = mode_mask(RESET_MODE);

  seq_state_t         state_q, state_d;
  pwr_mode_t          go_sleep_q, go_sleep_d;
  pwr_mode_t          mode_cur_q, mode_cur_d;
  pwr_mode_t          target_q, target_d;
  logic [NUM_DOM-1:0] delta_q, delta_d;
  logic [NUM_DOM-1:0] pwr_en_q, pwr_en_d;
  logic [NUM_DOM-1:0] iso_en_q, iso_en_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  pwr_mode_t          req_mode;
  logic [NUM_DOM-1:0] new_mask;
  logic [NUM_DOM-1:0] cur_mask;
  logic               tmr_load;
  logic [TW-1:0]      tmr_val;
  logic               tmr_expire;

  assign req_mode = pwr_mode_t'(mode_req);
  assign new_mask = mode_mask(req_mode);
  assign cur_mask = mode_mask(mode_cur_q);

  pwr_timer #(
    .W(TW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d    = state_q;
    go_sleep_d = go_sleep_q;
    mode_cur_d = mode_cur_q;
    target_d   = target_q;
    delta_d    = delta_q;
    pwr_en_d   = pwr_en_q;
    iso_en_d   = iso_en_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          target_d = req_mode;
          if (req_mode == mode_cur_q) begin
            done_d = 1'b1;
          end else if (req_mode < mode_cur_q) begin
            // Nested modes: a lower code means a strict subset of domains.
            delta_d    = cur_mask & ~new_mask;
            go_sleep_d = req_mode;
            state_d    = ST_ISO_ON;
          end else begin
            delta_d  = new_mask & ~cur_mask;
            pwr_en_d = pwr_en_q | (new_mask & ~cur_mask);
            tmr_load = 1'b1;
            tmr_val  = TMO_LD;
            state_d  = ST_PWR_ON;
          end
        end
      end

      ST_ISO_ON: begin
        iso_en_d = iso_en_q | delta_q;
        tmr_load = 1'b1;
        tmr_val  = ISO_LD;
        state_d  = ST_PWR_OFF;
      end

      ST_PWR_OFF: begin
        if (tmr_expire) begin
          pwr_en_d   = pwr_en_q & ~delta_q;
          mode_cur_d = target_q;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      ST_PWR_ON, ST_WAIT_ACK: begin
        // Ack is tested before expiry so a last-cycle ack still succeeds.
        if ((pwr_ack & delta_q) == delta_q) begin
          iso_en_d = iso_en_q & ~delta_q;
          state_d  = ST_ISO_OFF;
        end else if (tmr_expire) begin
          pwr_en_d = pwr_en_q & ~delta_q;
          done_d   = 1'b1;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_WAIT_ACK;
        end
      end

      ST_ISO_OFF: begin
        go_sleep_d = target_q;
        mode_cur_d = target_q;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      go_sleep_q <= RESET_MODE;
      mode_cur_q <= RESET_MODE;
      target_q   <= RESET_MODE;
      delta_q    <= '0;
      pwr_en_q   <= RST_MASK;
      iso_en_q   <= ~RST_MASK;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      go_sleep_q <= go_sleep_d;
      mode_cur_q <= mode_cur_d;
      target_q   <= target_d;
      delta_q    <= delta_d;
      pwr_en_q   <= pwr_en_d;
      iso_en_q   <= iso_en_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign req_ready = ready_q;
  assign pwr_en    = pwr_en_q;
  assign iso_en    = iso_en_q;
  assign go_sleep  = go_sleep_q;
  assign mode_cur  = mode_cur_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/alu_power_sequencer.md
Name: alu_power_sequencer

Overview:
- Power-mode controller directly upstream of dummyALU. It drives the ALU's go_sleep input and sequences the per-domain supply enables and isolation for the memory (VDDM), arithmetic (VDDA) and logic (VDDL/VDDLU) domains.
- Modes are nested: full ⊃ normal ⊃ low ⊃ sleep. Every transition is therefore either purely power-down or purely power-up.
- Down order: go_sleep, then isolation, then supply off. Up order: supply on, then ack, then de-isolation, then go_sleep.

Parameters:
- ISO_DLY, 2, cycles isolation is held before supplies drop (legal range ≥1).
- TIMEOUT, 8, maximum cycles to wait for pwr_ack on power-up (≥1).
- RESET_MODE, 2'b11, mode taken on reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  mode-change request.
- mode_req  in  2  requested mode: 11 full, 10 normal, 01 low, 00 sleep.
- req_ready  out  1  high in IDLE; a request is accepted when req_valid && req_ready.
- pwr_ack  in  3  per-domain supply-good; bit2 M, bit1 A, bit0 L.
- pwr_en  out  3  per-domain supply enable (same bit order as pwr_ack).
- iso_en  out  3  per-domain isolation enable.
- go_sleep  out  2  mode presented to the ALU.
- mode_cur  out  2  committed mode.
- done  out  1  one-cycle pulse when a request completes.
- err  out  1  one-cycle pulse with done on power-up timeout.

Behaviour:
- Domain mask per mode:
  - 11 → 111
  - 10 → 011
  - 01 → 010
  - 00 → 000
- Reset values (registered, next edge with rst_n=0, also mid-sequence): go_sleep=mode_cur=RESET_MODE, pwr_en=mask(RESET_MODE), iso_en=~mask(RESET_MODE), state IDLE, req_ready=1, done=0, err=0, timer cleared.
- All outputs are registered. mode_req is captured on accept. req_valid is ignored outside IDLE.
- States: IDLE, ISO_ON, PWR_OFF, PWR_ON, WAIT_ACK, ISO_OFF, COMMIT.
- Same-mode request, accepted at T: done=1 at T+1, no other output changes, stays IDLE.
- Down (mask_new ⊂ mask_cur), off = mask_cur & ~mask_new, accept at T:
  - T+1: go_sleep=target.
  - T+2: iso_en |= off; timer loaded with ISO_DLY.
  - T+2+ISO_DLY: pwr_en &= ~off; mode_cur=target; done=1; req_ready=1.
- Up (mask_new ⊃ mask_cur), on = mask_new & ~mask_cur, accept at T:
  - T+1: pwr_en |= on; timer loaded with TIMEOUT.
  - WAIT_ACK: each cycle tests (pwr_ack & on)==on; the first cycle it holds is U.
  - U+1: iso_en &= ~on.
  - U+2: go_sleep=mode_cur=target; done=1; IDLE.
- Up timeout: if the ack is not complete within TIMEOUT cycles after T+1, then on the next edge pwr_en &= ~on and done=err=1. iso_en, go_sleep and mode_cur are unchanged. Return to IDLE.
- An ack arriving in the same cycle the timer expires counts as success.
- pwr_ack is ignored outside WAIT_ACK; stale ack bits for non-'on' domains are don't-care.
- go_sleep never shows a mode whose domains are not powered and de-isolated.
- Timer width: $clog2(max(ISO_DLY,TIMEOUT)+1).

Decomposition:
- Package alu_pwr_pkg:
  - typedef enum logic[1:0] pwr_mode_t (MODE_SLEEP, MODE_LOW, MODE_NORMAL, MODE_FULL).
  - Domain index constants DOM_M=2, DOM_A=1, DOM_L=0.
  - Function mode_mask(pwr_mode_t) returning logic[2:0].
  - State enum.
- Sub-module pwr_timer: loadable down-counter with load and expire outputs, shared by the ISO_DLY and TIMEOUT phases.

Test Plan (ISO_DLY=2, TIMEOUT=8, clock cycle indices relative to accept T):
1. Reset, then req 10 at T → go_sleep=10 @T+1, iso_en=100 @T+2, pwr_en=011 + done + mode_cur=10 @T+4.
2. From 10, req 00 → go_sleep=00 @T+1, iso_en=111 @T+2, pwr_en=000 + done @T+4.
3. From 00, req 11 with pwr_ack=111 driven at T+3 → pwr_en=111 @T+1, iso_en=000 @T+4, go_sleep=11 + done @T+5.
4. From 01, req 11 with pwr_ack[2] held 0 → pwr_en=111 @T+1, then pwr_en=010 + done + err at timeout. go_sleep stays 01 and iso_en stays 101.
5. Same-mode req 11 while in 11 → done @T+1 only; req_valid pulses during a busy sequence are ignored (req_ready=0, no restart).
6. rst_n=0 during WAIT_ACK → next edge: go_sleep=11, pwr_en=111, iso_en=000, req_ready=1, done=err=0.
